// File: rtl/crc_checker.sv
// Serial CRC-8 receiver/checker.
// Recomputes the LFSR over a bit-serial payload framed by ACTIVE, then compares
// the following WIDTH serial CRC bits (framed by CRC_VALID, LSB first) against
// the remainder. A one-cycle DONE carries the pass/fail verdict; CRC_OK/ERR hold
// the verdict until the next frame starts.
module crc_checker #(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] SEED  = 8'hD8,
    parameter logic [WIDTH-1:0] TAPS  = 8'h44
) (
    input  logic CLK,
    input  logic RST,
    input  logic ACTIVE,
    input  logic DATA,
    input  logic CRC_VALID,
    input  logic CRC_IN,
    output logic BUSY,
    output logic DONE,
    output logic CRC_OK,
    output logic ERR
);

    // Counter must reach WIDTH-1; WIDTH is assumed to be at least 2.
    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StData,
        StCheck
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  lfsr_q, lfsr_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic              mis_q, mis_d;
    logic              done_q, done_d;
    logic              ok_q, ok_d;
    logic              err_q, err_d;

    logic              bit_mis;
    logic              mis_acc;
    logic              last_bit;

    // One payload bit through the Galois-style LFSR; TAPS[WIDTH-1] is unused
    // because the top bit always takes the feedback directly.
    function automatic logic [WIDTH-1:0] lfsr_step(input logic [WIDTH-1:0] cur,
                                                   input logic din);
        logic             fb;
        logic [WIDTH-1:0] mask;
        logic [WIDTH-1:0] nxt;
        fb          = din ^ cur[0];
        mask        = TAPS;
        mask[WIDTH-1] = 1'b0;
        nxt         = (cur >> 1) ^ ({WIDTH{fb}} & mask);
        nxt[WIDTH-1] = fb;
        return nxt;
    endfunction

    // State, LFSR, counter and verdict registers.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q <= StIdle;
            lfsr_q  <= SEED;
            cnt_q   <= '0;
            mis_q   <= 1'b0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            cnt_q   <= cnt_d;
            mis_q   <= mis_d;
            done_q  <= done_d;
            ok_q    <= ok_d;
            err_q   <= err_d;
        end
    end

    // Per-bit compare helpers used by the CHECK state.
    always_comb begin
        bit_mis  = CRC_IN ^ lfsr_q[0];
        mis_acc  = mis_q | bit_mis;
        last_bit = (cnt_q == CntW'(WIDTH - 1));
    end

    // Next-state logic: frame sequencing, LFSR update and verdict generation.
    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        cnt_d   = cnt_q;
        mis_d   = mis_q;
        done_d  = 1'b0;
        ok_d    = ok_q;
        err_d   = err_q;

        unique case (state_q)
            StIdle: begin
                lfsr_d = SEED;
                cnt_d  = '0;
                mis_d  = 1'b0;
                if (ACTIVE) begin
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    lfsr_d  = lfsr_step(SEED, DATA);
                    state_d = StData;
                end else if (CRC_VALID) begin
                    // Zero-length frame: first CRC bit is checked against SEED.
                    ok_d    = 1'b0;
                    err_d   = 1'b0;
                    mis_d   = CRC_IN ^ SEED[0];
                    lfsr_d  = SEED >> 1;
                    cnt_d   = CntW'(1);
                    state_d = StCheck;
                end
            end

            StData: begin
                if (ACTIVE) begin
                    lfsr_d = lfsr_step(lfsr_q, DATA);
                end else if (CRC_VALID) begin
                    // First CRC bit is compared in the transition cycle.
                    mis_d   = bit_mis;
                    lfsr_d  = lfsr_q >> 1;
                    cnt_d   = CntW'(1);
                    state_d = StCheck;
                end
                // Both low: gap, LFSR holds.
            end

            StCheck: begin
                if (ACTIVE || !CRC_VALID) begin
                    // Protocol error: ACTIVE bit is discarded, not consumed.
                    state_d = StIdle;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    done_d  = 1'b1;
                    ok_d    = 1'b0;
                    err_d   = 1'b1;
                end else if (last_bit) begin
                    state_d = StIdle;
                    lfsr_d  = SEED;
                    cnt_d   = '0;
                    mis_d   = 1'b0;
                    done_d  = 1'b1;
                    ok_d    = ~mis_acc;
                    err_d   = mis_acc;
                end else begin
                    mis_d  = mis_acc;
                    lfsr_d = lfsr_q >> 1;
                    cnt_d  = cnt_q + CntW'(1);
                end
            end

            default: begin
                state_d = StIdle;
                lfsr_d  = SEED;
                cnt_d   = '0;
                mis_d   = 1'b0;
            end
        endcase
    end

    // Outputs are straight from registers, except BUSY which decodes the state.
    always_comb begin
        BUSY   = (state_q != StIdle);
        DONE   = done_q;
        CRC_OK = ok_q;
        ERR    = err_q;
    end

    // Verdict flags are mutually exclusive; DONE is a single-cycle pulse.
    a_ok_err_excl: assert property (@(posedge CLK) disable iff (!RST) !(ok_q && err_q));
    a_done_pulse:  assert property (@(posedge CLK) disable iff (!RST) done_q |=> !done_q);

endmodule

// File: doc/crc_checker.md
Name: crc_checker

Overview:
Serial CRC-8 receiver/checker, the far-end counterpart of the team's serial CRC generator. It recomputes the LFSR over an incoming bit-serial data stream framed by ACTIVE, then compares the following 8 serial CRC bits (framed by CRC_VALID) against its own remainder. It reports a one-cycle DONE with a pass/fail verdict. It sits at the link receive side, directly fed by the generator's DATA/cRc/Valid-style signalling.

Parameters:
WIDTH, 8, CRC/LFSR width and number of CRC bits checked per frame
SEED, 8'hD8, LFSR value loaded on reset and at every frame start
TAPS, 8'h44, feedback XOR mask: bit i set means the feedback XORs into LFSR bit i (i = 0..WIDTH-2)

Ports:
CLK  input  1  clock, all flops rising-edge
RST  input  1  asynchronous, active-low reset
ACTIVE  input  1  high while DATA carries a payload bit
DATA  input  1  serial payload, one bit per cycle, in the order the generator sends it
CRC_VALID  input  1  high while CRC_IN carries a CRC bit
CRC_IN  input  1  serial CRC, LSB (remainder bit 0) first
BUSY  output  1  high while a frame is in progress (state DATA or CHECK)
DONE  output  1  one-cycle pulse when the verdict is available
CRC_OK  output  1  verdict: all WIDTH CRC bits matched; held until the next frame starts
ERR  output  1  verdict: mismatch or protocol error; held until the next frame starts

Behaviour:
- Reset (RST=0, async): state IDLE, lfsr=SEED, bit counter=0, BUSY=0, DONE=0, CRC_OK=0, ERR=0.
- LFSR update on an ACTIVE cycle: fb = DATA ^ lfsr[0]; lfsr_n[WIDTH-1] = fb; lfsr_n[i] = lfsr[i+1] ^ (TAPS[i] & fb).
- IDLE: lfsr held at SEED.
  - ACTIVE=1: clear CRC_OK/ERR, consume the bit, go to DATA.
  - Else CRC_VALID=1 (zero-length frame): clear CRC_OK/ERR, compare against SEED, go to CHECK.
  - ACTIVE has priority if both are high.
- DATA:
  - ACTIVE=1: update the LFSR.
  - ACTIVE=0, CRC_VALID=1: go to CHECK, comparing the first CRC bit in that same cycle.
  - Both low: hold the LFSR (gap allowed), stay in DATA.
- CHECK: each cycle with CRC_VALID=1:
  - mismatch |= (CRC_IN != lfsr[0]).
  - lfsr shifts right, zero-filled.
  - counter increments.
  - When the WIDTH-th bit is compared, the next edge goes to IDLE and registers DONE=1 for one cycle, CRC_OK = ~mismatch, ERR = mismatch.
- Protocol errors in CHECK:
  - CRC_VALID drops before WIDTH bits, or ACTIVE rises: abort to IDLE with DONE=1, ERR=1, CRC_OK=0.
  - The cycle in which ACTIVE rises is not consumed as data.
- Latency: DONE/CRC_OK/ERR are visible in the cycle after the last CRC bit is sampled.
- CRC_OK and ERR are never both 1. DONE is never high in two consecutive cycles.
- Back-to-back frames: ACTIVE may rise in the same cycle DONE is high; that frame starts normally from SEED and clears the verdict.
- Reset mid-frame: immediate return to the reset values; no DONE is issued.

Test Plan:
- DATA=8'h00 sent bit0 first with ACTIVE for 8 cycles, then CRC_IN=8'h14 LSB-first with CRC_VALID for 8 cycles -> DONE pulse 1 cycle after the last bit, CRC_OK=1, ERR=0, BUSY low thereafter.
- Same payload, CRC_IN=8'h15 (bit0 flipped) -> DONE, CRC_OK=0, ERR=1; verdict held until the next ACTIVE.
- Zero-length frame: CRC_VALID only, CRC_IN=8'hD8 -> CRC_OK=1. Repeat with 8'hD9 -> ERR=1.
- Payload 8'h00 with a 3-cycle ACTIVE gap after bit 4 -> still CRC_OK=1 with CRC 8'h14. CRC_VALID dropped after 5 bits -> DONE with ERR=1.
- RST pulsed low mid-CRC (bit 3) -> all outputs 0 asynchronously, no DONE. Next full 8'h00/8'h14 frame -> CRC_OK=1.
- Two back-to-back good frames with ACTIVE rising on the DONE cycle -> two DONE pulses, both CRC_OK=1, verdict cleared between them.
